// File: rtl/btn_pkg.sv
// Shared types and default constants for the push-button conditioner.
// Long-press detection is compiled in with `define BTN_LONG_PRESS_EN.
package btn_pkg;

    localparam int BTN_DEBOUNCE_DEFAULT = 4;
    localparam int BTN_LONG_DEFAULT     = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

endpackage : btn_pkg

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
// Synchronous active-low reset; reusable for any slow board input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // NOTE: sequential state uses non-blocking assignments so both flops
    // sample their inputs from the same edge and form a real two-stage chain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule : sync2

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronizer, debounce FSM, registered event pulses.
// Optional long-press pulse is built when BTN_LONG_PRESS_EN is defined.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = BTN_LONG_DEFAULT,
    parameter int CNT_W             = $clog2(LONG_PRESS_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic A,
    output logic level,
    output logic press,
    output logic release_o,   // "release" is a reserved word in SystemVerilog
    output logic long_press
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             a_s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (A),
        .q     (a_s)
    );

    // NOTE: every always_comb output gets a default first, so no path
    // through the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (a_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!a_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!a_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                if (a_s) begin
                    state_d = PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level     = level_q;
    assign press     = press_q;
    assign release_o = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_PRESS_CYCLES);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             long_q, long_d;

    // hold saturates one past the firing value, so the pulse cannot repeat
    // within a press even after bouncing through RELEASE_WAIT.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q == PRESS_WAIT && a_s && cnt_q == DEB_LAST) begin
            hold_d = '0;
        end else if (state_q == PRESSED && a_s) begin
            if (hold_q == LONG_LAST) begin
                long_d = 1'b1;
            end
            if (hold_q != LONG_MAX) begin
                hold_d = hold_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule : btn_debounce

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random bouncing,
// compared every cycle against a run-length reference model.
module tb_btn_debounce;

    localparam int DEB  = 4;
    localparam int LONG = 16;
`ifdef BTN_LONG_PRESS_EN
    localparam int LONG_EN = 1;
`else
    localparam int LONG_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic A;
    logic level, press, release_o, long_press;

    btn_debounce #(
        .DEBOUNCE_CYCLES   (DEB),
        .LONG_PRESS_CYCLES (LONG)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .A          (A),
        .level      (level),
        .press      (press),
        .release_o  (release_o),
        .long_press (long_press)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit dl[$];
    bit m_level, m_prev;
    int m_run, m_hold;
    bit e_press, e_rel, e_long;

    // observation tallies
    int edge_n = 0;
    int n_press = 0, n_rel = 0, n_long = 0, n_coinc = 0, n_alt_err = 0;
    int last_press_edge = 0, last_rel_edge = 0, last_long_edge = 0;
    int last_evt = 0; // 0 none, 1 press, 2 release
    logic [3:0] o_vec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the accepted level flips after DEB consecutive synchronized
    // samples disagree with it; hold counts high samples following a high sample.
    task automatic model_edge(input bit a, input bit r);
        bit s;
        e_press = 0; e_rel = 0; e_long = 0;
        if (!r) begin
            dl = '{1'b0, 1'b0};
            m_level = 0; m_prev = 0; m_run = 0; m_hold = 0;
        end else begin
            s = dl.pop_front();
            dl.push_back(a);
            if (s != m_level) m_run++;
            else m_run = 0;
            if (m_run == DEB) begin
                m_level = s;
                m_run = 0;
                if (s) begin
                    e_press = 1;
                    m_hold = 0;
                end else begin
                    e_rel = 1;
                end
            end else if (m_level && s && m_prev) begin
                m_hold++;
                if (m_hold == LONG) e_long = (LONG_EN != 0);
            end
            m_prev = s;
        end
    endtask

    task automatic cycle(input bit a, input bit r);
        int idx;
        A = a;
        rst_n = r;
        @(posedge clk);
        idx = edge_n;
        edge_n++;
        model_edge(a, r);
        #1;
        check("level", 32'(level), 32'(m_level));
        check("press", 32'(press), 32'(e_press));
        check("release", 32'(release_o), 32'(e_rel));
        check("long_press", 32'(long_press), 32'(e_long));
        o_vec = {level, press, release_o, long_press};
        if (press === 1'b1 && release_o === 1'b1) n_coinc++;
        if (press === 1'b1) begin
            n_press++;
            last_press_edge = idx;
            if (last_evt == 1) n_alt_err++;
            last_evt = 1;
        end
        if (release_o === 1'b1) begin
            n_rel++;
            last_rel_edge = idx;
            if (last_evt == 2) n_alt_err++;
            last_evt = 2;
        end
        if (long_press === 1'b1) begin
            n_long++;
            last_long_edge = idx;
        end
    endtask

    task automatic hold_level(input bit a, input int n);
        for (int i = 0; i < n; i++) cycle(a, 1'b1);
    endtask

    initial begin
        int t0, p0, r0, l0;
        bit bv [7];
        A = 1'b0;
        rst_n = 1'b0;
        dl = '{1'b0, 1'b0};

        // reset
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
        check("reset_outputs", 32'(o_vec), 32'd0);
        hold_level(1'b0, 3);

        // clean press and release
        t0 = edge_n; p0 = n_press; r0 = n_rel;
        hold_level(1'b1, 20);
        check("clean_press_count", 32'(n_press - p0), 32'd1);
        check("clean_press_edge", 32'(last_press_edge - t0), 32'd5);
        t0 = edge_n;
        hold_level(1'b0, 10);
        check("clean_release_count", 32'(n_rel - r0), 32'd1);
        check("clean_release_edge", 32'(last_rel_edge - t0), 32'd5);

        // bounce on press
        p0 = n_press;
        bv = '{1, 1, 0, 1, 1, 1, 1};
        foreach (bv[i]) cycle(bv[i], 1'b1);
        hold_level(1'b1, 4);
        check("bounce_press_count", 32'(n_press - p0), 32'd1);
        hold_level(1'b0, 10);

        // bounce on release
        hold_level(1'b1, 12);
        r0 = n_rel;
        bv = '{0, 0, 1, 0, 0, 0, 0};
        foreach (bv[i]) cycle(bv[i], 1'b1);
        hold_level(1'b0, 6);
        check("bounce_release_count", 32'(n_rel - r0), 32'd1);

        // long hold
        p0 = n_press; l0 = n_long;
        hold_level(1'b1, 40);
        check("long_press_count", 32'(n_long - l0), 32'(LONG_EN));
        check("long_hold_press_count", 32'(n_press - p0), 32'd1);
`ifdef BTN_LONG_PRESS_EN
        check("long_press_offset", 32'(last_long_edge - last_press_edge), 32'(LONG));
`endif
        hold_level(1'b0, 10);

        // reset while pressed, button still held
        hold_level(1'b1, 10);
        cycle(1'b1, 1'b0);
        check("midhold_reset_outputs", 32'(o_vec), 32'd0);
        cycle(1'b1, 1'b0);
        t0 = edge_n; p0 = n_press;
        hold_level(1'b1, 10);
        check("post_reset_press_count", 32'(n_press - p0), 32'd1);
        check("post_reset_press_edge", 32'(last_press_edge - t0), 32'd5);
        hold_level(1'b0, 10);

        // rapid presses
        p0 = n_press; r0 = n_rel; n_alt_err = 0; n_coinc = 0;
        for (int k = 0; k < 3; k++) begin
            hold_level(1'b1, 8);
            hold_level(1'b0, 8);
        end
        check("rapid_press_count", 32'(n_press - p0), 32'd3);
        check("rapid_release_count", 32'(n_rel - r0), 32'd3);
        check("rapid_alternation", 32'(n_alt_err), 32'd0);

        // random bouncing with occasional resets
        n_coinc = 0;
        for (int seg = 0; seg < 60; seg++) begin
            if ($urandom_range(0, 14) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, 2)); i++)
                    cycle(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                hold_level(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
            end
        end
        hold_level(1'b0, 10);
        check("no_coincident_pulses", 32'(n_coinc), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_btn_debounce
